// File: rtl/hpu_pkg.sv
// Shared HPU definitions: VRAM requester identifiers and the default memory port widths.
package hpu_pkg;

   localparam int HPU_ADDR_W = 16;
   localparam int HPU_DATA_W = 8;

   typedef enum logic [1:0] {
      REQ_TILE,
      REQ_SPR,
      REQ_HOST
   } hpu_req_e;

endpackage

// File: rtl/hpu_wr_fifo.sv
// Synchronous FIFO that buffers host writes as {addr,data} words until the arbiter drains them.
// Push is ignored when full and pop is ignored when empty; there is no bypass from push to head.
module hpu_wr_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_data,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_data,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_level
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_level;
   logic             w_push;
   logic             w_pop;

   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_full  = (r_level == (PTR_W+1)'(DEPTH));
   assign o_empty = (r_level == '0);
   assign o_level = r_level;
   assign o_data  = r_mem[r_rd_ptr];

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         // Pointers wrap naturally because DEPTH is a power of two.
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   // NOTE: storage is not reset; the pointers and level alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/hpu_vram_arbiter.sv
// Shares the HPU VRAM port: tile fetch has fixed priority, sprite reads and buffered host writes alternate.
// Define HPU_ARB_STATS_EN to add the spr_stall_cnt/host_stall_cnt saturating stall counters.
module hpu_vram_arbiter
   import hpu_pkg::*;
#(
   parameter int ADDR_W     = HPU_ADDR_W,
   parameter int DATA_W     = HPU_DATA_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        tile_req,
   input  logic [ADDR_W-1:0]           tile_addr,
   output logic                        tile_rvalid,
   input  logic                        spr_req,
   input  logic [ADDR_W-1:0]           spr_addr,
   output logic                        spr_gnt,
   output logic                        spr_rvalid,
   input  logic                        host_wr_valid,
   output logic                        host_wr_ready,
   input  logic [ADDR_W-1:0]           host_wr_addr,
   input  logic [DATA_W-1:0]           host_wr_data,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic                        mem_we,
   output logic [DATA_W-1:0]           mem_wdata,
   input  logic [DATA_W-1:0]           mem_rdata,
   output logic [DATA_W-1:0]           rdata,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
`ifdef HPU_ARB_STATS_EN
   ,
   output logic [15:0]                 spr_stall_cnt,
   output logic [15:0]                 host_stall_cnt
`endif
);

   logic [ADDR_W+DATA_W-1:0] w_fifo_head;
   logic [ADDR_W-1:0]        w_fifo_addr;
   logic [DATA_W-1:0]        w_fifo_data;
   logic                     w_fifo_full;
   logic                     w_fifo_empty;
   logic                     w_host_pend;
   logic                     w_issue;
   logic                     w_rr_update;
   hpu_req_e                 w_sel;
   logic                     w_tile_win;
   logic                     w_spr_win;
   logic                     w_host_win;
   hpu_req_e                 r_rr_last;
   logic                     r_rd_tile;
   logic                     r_rd_spr;

   assign host_wr_ready = !w_fifo_full;
   assign w_host_pend   = !w_fifo_empty;
   assign {w_fifo_addr, w_fifo_data} = w_fifo_head;

   hpu_wr_fifo #(
      .WIDTH (ADDR_W + DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_wr_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (host_wr_valid && host_wr_ready),
      .i_data  ({host_wr_addr, host_wr_data}),
      .i_pop   (w_host_win),
      .o_data  (w_fifo_head),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_level (fifo_level)
   );

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      w_issue     = 1'b0;
      w_rr_update = 1'b0;
      w_sel       = REQ_TILE;
      // Grants are suppressed while reset is held so no pop or gnt escapes during reset.
      if (!reset) begin
         if (tile_req) begin
            w_issue = 1'b1;
            w_sel   = REQ_TILE;
         end else if (spr_req && w_host_pend) begin
            w_issue     = 1'b1;
            w_rr_update = 1'b1;
            w_sel       = (r_rr_last == REQ_SPR) ? REQ_HOST : REQ_SPR;
         end else if (spr_req) begin
            w_issue = 1'b1;
            w_sel   = REQ_SPR;
         end else if (w_host_pend) begin
            w_issue = 1'b1;
            w_sel   = REQ_HOST;
         end
      end
   end

   assign w_tile_win = w_issue && (w_sel == REQ_TILE);
   assign w_spr_win  = w_issue && (w_sel == REQ_SPR);
   assign w_host_win = w_issue && (w_sel == REQ_HOST);
   assign spr_gnt    = w_spr_win;

   // Read tags travel one stage behind the command so they line up with the registered rdata.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rr_last   <= REQ_HOST;
         mem_addr    <= '0;
         mem_we      <= 1'b0;
         mem_wdata   <= '0;
         r_rd_tile   <= 1'b0;
         r_rd_spr    <= 1'b0;
         rdata       <= '0;
         tile_rvalid <= 1'b0;
         spr_rvalid  <= 1'b0;
      end else begin
         if (w_rr_update) r_rr_last <= w_sel;
         mem_we      <= w_host_win;
         r_rd_tile   <= w_tile_win;
         r_rd_spr    <= w_spr_win;
         rdata       <= mem_rdata;
         tile_rvalid <= r_rd_tile;
         spr_rvalid  <= r_rd_spr;
         if (w_issue) begin
            case (w_sel)
               REQ_TILE: mem_addr <= tile_addr;
               REQ_SPR:  mem_addr <= spr_addr;
               default: begin
                  mem_addr  <= w_fifo_addr;
                  mem_wdata <= w_fifo_data;
               end
            endcase
         end
      end
   end

`ifdef HPU_ARB_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         spr_stall_cnt  <= '0;
         host_stall_cnt <= '0;
      end else begin
         if (spr_req && !w_spr_win && spr_stall_cnt != 16'hFFFF)
            spr_stall_cnt <= spr_stall_cnt + 16'd1;
         if (w_host_pend && !w_host_win && host_stall_cnt != 16'hFFFF)
            host_stall_cnt <= host_stall_cnt + 16'd1;
      end
   end
`endif

endmodule
